// File: rtl/load_extend_ctrl_pkg.sv
// Shared definitions for the load sequencer: size encodings, FSM states and defaults.
// Optional build macro used by the top: LOAD_STATS_EN.
package load_extend_ctrl_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int unsigned DEFAULT_TIMEOUT = 16;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StResp
  } state_e;

endpackage

// File: rtl/load_extend_ctrl_lane_sign_ext.sv
// Combinational lane select and sign/zero extension of a little-endian memory word.
module lane_sign_ext
  import load_extend_ctrl_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] ext
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Pick the addressed lane and fill the upper bits from its MSB or with zeros.
  always_comb begin
    byte_v = word[7:0];
    unique case (addr)
      2'd0: byte_v = word[7:0];
      2'd1: byte_v = word[15:8];
      2'd2: byte_v = word[23:16];
      2'd3: byte_v = word[31:24];
      default: byte_v = word[7:0];
    endcase
    half_v = addr[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: ext = uns ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
      SZ_HALF: ext = uns ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
      default: ext = word;
    endcase
  end

endmodule

// File: rtl/load_extend_ctrl.sv
// Multi-cycle load sequencer: alignment check, word read over req/ack, lane extract
// and extension, one-cycle response pulse with error flag.
// Build macro LOAD_STATS_EN adds saturating success/error response counters.
module load_extend_ctrl
  import load_extend_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [1:0]        ld_size,
  input  logic              ld_unsigned,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_data,
  output logic              rsp_err,
`ifdef LOAD_STATS_EN
  output logic [15:0]       stat_loads,
  output logic [15:0]       stat_errs,
`endif
  output logic              busy
);

  // Counter only needs to reach TIMEOUT-1; the abort decision is taken in that cycle.
  localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [1:0]        lane_q, lane_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic [31:0]       ext;
  logic              bad_req;

  lane_sign_ext u_lane (
    .word (mem_rdata),
    .addr (lane_q),
    .size (size_q),
    .uns  (uns_q),
    .ext  (ext)
  );

  // Illegal size or a halfword/word not aligned to its natural boundary.
  always_comb begin
    bad_req = (ld_size == 2'b11) ||
              ((ld_size == SZ_HALF) && ld_addr[0]) ||
              ((ld_size == SZ_WORD) && (ld_addr[1:0] != 2'b00));
  end

  // Next-state and datapath capture.
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    lane_d     = lane_q;
    size_d     = size_q;
    uns_d      = uns_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    unique case (state_q)
      StIdle: begin
        if (ld_valid) begin
          mem_addr_d = {ld_addr[ADDR_W-1:2], 2'b00};
          lane_d     = ld_addr[1:0];
          size_d     = ld_size;
          uns_d      = ld_unsigned;
          cnt_d      = '0;
          if (bad_req) begin
            rsp_err_d  = 1'b1;
            rsp_data_d = 32'h0;
            state_d    = StResp;
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        // Ack is checked first so a same-cycle ack beats the timeout.
        if (mem_ack) begin
          rsp_data_d = ext;
          rsp_err_d  = 1'b0;
          state_d    = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            rsp_err_d  = 1'b1;
            rsp_data_d = 32'h0;
            state_d    = StResp;
          end
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and captured request/response registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= StIdle;
      mem_addr_q <= '0;
      lane_q     <= 2'b00;
      size_q     <= SZ_BYTE;
      uns_q      <= 1'b0;
      cnt_q      <= '0;
      rsp_data_q <= 32'h0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      lane_q     <= lane_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Outputs decoded from state.
  always_comb begin
    ld_ready  = (state_q == StIdle);
    mem_req   = (state_q == StReq);
    rsp_valid = (state_q == StResp);
    busy      = (state_q != StIdle);
    mem_addr  = mem_addr_q;
    rsp_data  = rsp_data_q;
    rsp_err   = rsp_err_q;
  end

`ifdef LOAD_STATS_EN
  logic [15:0] stat_loads_q, stat_errs_q;

  // Saturating response counters, bumped during the response cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stat_loads_q <= 16'h0;
      stat_errs_q  <= 16'h0;
    end else if (state_q == StResp) begin
      if (rsp_err_q) begin
        if (stat_errs_q != 16'hFFFF) stat_errs_q <= stat_errs_q + 16'h1;
      end else begin
        if (stat_loads_q != 16'hFFFF) stat_loads_q <= stat_loads_q + 16'h1;
      end
    end
  end

  assign stat_loads = stat_loads_q;
  assign stat_errs  = stat_errs_q;
`endif

endmodule

// File: tb/tb_load_extend_ctrl.sv
// Scoreboard bench for load_extend_ctrl: directed loads push expected responses,
// a negedge monitor pops and compares every rsp_valid pulse.
module tb_load_extend_ctrl;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [31:0] ld_addr = 32'h0;
  logic [1:0]  ld_size = 2'b00;
  logic        ld_unsigned = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;
`ifdef LOAD_STATS_EN
  logic [15:0] stat_loads;
  logic [15:0] stat_errs;
`endif

  int checks = 0;
  int errors = 0;
  int exp_loads = 0;
  int exp_errs = 0;
  logic [32:0] exp_q[$];

  load_extend_ctrl #(
    .TIMEOUT (16),
    .ADDR_W  (32)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_addr     (ld_addr),
    .ld_size     (ld_size),
    .ld_unsigned (ld_unsigned),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
`ifdef LOAD_STATS_EN
    .stat_loads  (stat_loads),
    .stat_errs   (stat_errs),
`endif
    .busy        (busy)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every response pulse must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got err=%b data=%h, expected no response",
                 rsp_err, rsp_data);
      end else begin
        check("rsp", {rsp_err, rsp_data}, exp_q.pop_front());
      end
    end
  end

  task automatic do_reset();
    Reset = 1'b1;
    repeat (2) begin @(posedge Clk); #1; end
    Reset = 1'b0;
    mem_ack = 1'b0;
    exp_loads = 0;
    exp_errs = 0;
  endtask

  task automatic do_load(input string name, input logic [31:0] a, input logic [1:0] sz,
                         input logic u, input int ack_after, input logic [31:0] rdata,
                         input logic [31:0] exp_d, input logic exp_e);
    exp_q.push_back({exp_e, exp_d});
    if (exp_e) exp_errs++; else exp_loads++;
    ld_valid = 1'b1; ld_addr = a; ld_size = sz; ld_unsigned = u;
    @(posedge Clk); #1;
    ld_valid = 1'b0;
    @(negedge Clk);
    if (exp_e) begin
      check({name, "_no_mem_req"}, mem_req, 1'b0);
      check({name, "_err_latency"}, rsp_valid, 1'b1);
    end else begin
      check({name, "_mem_req"}, mem_req, 1'b1);
      check({name, "_mem_addr"}, mem_addr, {a[31:2], 2'b00});
      repeat (ack_after) begin @(posedge Clk); #1; end
      mem_ack = 1'b1; mem_rdata = rdata;
      @(posedge Clk); #1;
      mem_ack = 1'b0;
      @(negedge Clk);
      check({name, "_rsp_latency"}, rsp_valid, 1'b1);
    end
    @(posedge Clk); #1;
    @(negedge Clk);
    check({name, "_pulse_one_cycle"}, rsp_valid, 1'b0);
    check({name, "_ready_after"}, ld_ready, 1'b1);
  endtask

  logic [8:0] rv_pat, rd_pat;
  int n;

  initial begin
    // Reset state
    do_reset();
    @(negedge Clk);
    check("rst_ready", ld_ready, 1'b1);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_busy", busy, 1'b0);

    // Lane select and extension
    do_load("sbyte_l3", 32'h103, 2'b00, 1'b0, 2, 32'h80AB_CD12, 32'hFFFF_FF80, 1'b0);
    do_load("uhalf_hi", 32'h202, 2'b01, 1'b1, 1, 32'hBEEF_0001, 32'h0000_BEEF, 1'b0);
    do_load("shalf_hi", 32'h202, 2'b01, 1'b0, 0, 32'hBEEF_0001, 32'hFFFF_BEEF, 1'b0);
    do_load("ubyte_l1", 32'h501, 2'b00, 1'b1, 0, 32'h1234_5678, 32'h0000_0056, 1'b0);
    do_load("sbyte_l0", 32'h504, 2'b00, 1'b0, 3, 32'h0000_00F0, 32'hFFFF_FFF0, 1'b0);
    do_load("shalf_lo", 32'h600, 2'b01, 1'b0, 0, 32'hFFFF_7FFF, 32'h0000_7FFF, 1'b0);
    do_load("word", 32'h700, 2'b10, 1'b0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);

    // Misaligned and illegal
    do_load("mis_half", 32'h301, 2'b01, 1'b0, 0, 32'h0, 32'h0, 1'b1);
    do_load("mis_word", 32'h302, 2'b10, 1'b0, 0, 32'h0, 32'h0, 1'b1);
    do_load("ill_size", 32'h400, 2'b11, 1'b0, 0, 32'h0, 32'h0, 1'b1);

    // Ack outside REQ is ignored
    mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    repeat (3) begin @(posedge Clk); #1; end
    mem_ack = 1'b0;
    @(negedge Clk);
    check("idle_ack_busy", busy, 1'b0);

    // Timeout: mem_req for exactly 16 cycles, then error response
    exp_q.push_back({1'b1, 32'h0});
    exp_errs++;
    ld_valid = 1'b1; ld_addr = 32'h800; ld_size = 2'b10; ld_unsigned = 1'b0;
    @(posedge Clk); #1;
    ld_valid = 1'b0;
    n = 0;
    @(negedge Clk);
    while (mem_req && n < 40) begin
      n++;
      @(negedge Clk);
    end
    check("timeout_req_cycles", n, 16);
    check("timeout_rsp_valid", rsp_valid, 1'b1);
    @(posedge Clk); #1;

    // Ack in the 16th REQ cycle wins over timeout
    do_load("ack_at_timeout", 32'h900, 2'b10, 1'b0, 15, 32'h0000_00A5, 32'h0000_00A5, 1'b0);

    // Reset in 2nd REQ cycle with ack asserted: no response
    ld_valid = 1'b1; ld_addr = 32'hA00; ld_size = 2'b10;
    @(posedge Clk); #1;
    ld_valid = 1'b0;
    @(posedge Clk); #1;
    Reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    @(posedge Clk); #1;
    Reset = 1'b0; mem_ack = 1'b0;
    exp_loads = 0; exp_errs = 0;
    @(negedge Clk);
    check("rst_mid_mem_req", mem_req, 1'b0);
    check("rst_mid_ready", ld_ready, 1'b1);
    check("rst_mid_rsp_valid", rsp_valid, 1'b0);
    repeat (3) begin @(posedge Clk); #1; end

    // Back-to-back with ack tied high
    repeat (3) exp_q.push_back({1'b0, 32'h1357_9BDF});
    exp_loads += 3;
    mem_ack = 1'b1; mem_rdata = 32'h1357_9BDF;
    ld_valid = 1'b1; ld_addr = 32'hB00; ld_size = 2'b10;
    for (int i = 0; i < 9; i++) begin
      @(negedge Clk);
      rv_pat[i] = rsp_valid;
      rd_pat[i] = ld_ready;
      @(posedge Clk); #1;
    end
    ld_valid = 1'b0; mem_ack = 1'b0;
    check("b2b_rsp_pattern", rv_pat, 9'b100100100);
    check("b2b_ready_pattern", rd_pat, 9'b001001001);

    repeat (3) begin @(posedge Clk); #1; end
    @(negedge Clk);
    check("queue_drained", exp_q.size(), 0);
`ifdef LOAD_STATS_EN
    check("stat_loads", stat_loads, exp_loads);
    check("stat_errs", stat_errs, exp_errs);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/load_extend_ctrl.md
Name: load_extend_ctrl

Overview:
Multi-cycle load sequencer between the MEM stage and a word-addressed data memory with a req/ack handshake. Accepts one load at a time and checks alignment. Issues a word read and selects the byte or halfword lane (little-endian). Sign- or zero-extends the result to 32 bits and returns it with a one-cycle response pulse. Also flags misaligned accesses and memory timeouts.

Parameters:
TIMEOUT, 16, cycles in REQ without mem_ack before aborting with error (minimum 1)
ADDR_W, 32, load address width

Ports:
Clk  input  1  system clock, all state on rising edge
Reset  input  1  synchronous, active-high reset
ld_valid  input  1  load request valid
ld_ready  output  1  controller can accept a request (IDLE only)
ld_addr  input  ADDR_W  byte address
ld_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
ld_unsigned  input  1  1 = zero-extend, 0 = sign-extend (ignored for word)
mem_req  output  1  memory read request, held until mem_ack
mem_addr  output  ADDR_W  word-aligned address (ld_addr with [1:0] forced to 0)
mem_ack  input  1  memory read data valid this cycle
mem_rdata  input  32  memory read word
rsp_valid  output  1  one-cycle response pulse
rsp_data  output  32  extended load result
rsp_err  output  1  qualifies rsp_valid: misaligned, illegal size or timeout
busy  output  1  state != IDLE

Behaviour:
- Clock and reset: one clock (Clk); Reset is synchronous and active-high.
- Reset values: state IDLE, mem_req 0, mem_addr 0, rsp_valid 0, rsp_data 0, rsp_err 0, timeout counter 0. ld_ready is 1 in the cycle after Reset deasserts.
- Reset mid-operation:
  - Any state returns to IDLE next edge.
  - An in-flight mem_ack is ignored and no response is produced.
- FSM states: IDLE, REQ, RESP.
- IDLE: ld_ready=1. When ld_valid is high, latch addr, size and unsigned.
  - Misaligned or illegal request (ld_size=11; half with addr[0]=1; word with addr[1:0]!=0): go to RESP with rsp_err=1, rsp_data=0. No memory access.
  - Otherwise go to REQ.
- REQ: mem_req=1, mem_addr stable. The counter increments each cycle mem_ack is low.
  - On mem_ack: capture the extended result, rsp_err=0, go to RESP. mem_ack in the first REQ cycle is legal.
  - If the counter reaches TIMEOUT without ack: rsp_err=1, rsp_data=0, go to RESP.
  - If ack and timeout occur in the same cycle, ack wins.
  - mem_ack in IDLE or RESP is ignored.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. ld_ready=0, so back-to-back accepts are spaced at least 3 cycles apart for aligned loads.
- rsp_data and rsp_err hold their values until the next response; they are meaningful only while rsp_valid=1.
- Latency: accept at edge 0, mem_req visible cycle 1, earliest rsp_valid cycle 2. Error path: rsp_valid cycle 1.
- Lane select (little-endian):
  - Byte: lane addr[1:0]; lane 0 = rdata[7:0].
  - Half: addr[1]=0 gives rdata[15:0], addr[1]=1 gives rdata[31:16].
  - Word: passthrough.
- Extension: bits above the lane are filled with the lane MSB (signed) or 0 (unsigned).

Optional Feature:
LOAD_STATS_EN.
- Defined: adds output ports stat_loads[15:0] and stat_errs[15:0].
  - stat_loads counts successful responses; stat_errs counts error responses.
  - Both saturate at 16'hFFFF and clear on Reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), state enum, default TIMEOUT constant.
- Sub-module lane_sign_ext: purely combinational. Inputs word, addr[1:0], size, unsigned; output 32-bit extended value. Instantiated once; used by the ack capture path.

Test Plan:
- Signed byte: ld_addr=0x103, size=00, unsigned=0; ack after 2 cycles with rdata=0x80AB_CD12 -> rsp_valid once, rsp_data=0xFFFF_FF80, rsp_err=0; mem_addr=0x100.
- Unsigned half: ld_addr=0x202, size=01, unsigned=1; rdata=0xBEEF_0001 -> rsp_data=0x0000_BEEF; same with unsigned=0 -> 0xFFFF_BEEF.
- Misaligned: half at 0x301, and word at 0x302 -> no mem_req; rsp_valid at cycle 1 with rsp_err=1, rsp_data=0. size=11 behaves the same.
- Timeout: TIMEOUT=16, never ack -> mem_req high 16 cycles, then rsp_err=1. Ack in the same cycle as timeout -> rsp_err=0 with valid data.
- Reset mid-REQ: Reset high in the 2nd REQ cycle while mem_ack=1 -> no rsp_valid; mem_req=0 and ld_ready=1 after Reset deasserts.
- Back-to-back with same-cycle ack: ld_valid held high across 3 loads, mem_ack tied high -> each response 2 cycles after accept, accepts 3 cycles apart. With LOAD_STATS_EN: stat_loads=3, stat_errs=0.
